adc_acq_controller: RTL and testbench
=====================================

Name: adc_acq_controller

Overview:
- Sequences one ADC acquisition session: issues the nSYNC pulse, waits for the ADC to settle, gates captured 4-lane frames into a 2-entry buffer, and hands them downstream over valid/ready.
- Sits between the frame capture stage (which supplies a one-cycle FRAME_STROBE and the frame word) and the consumer (DSP/packetiser).
- Supervises nDRDY cadence and flags settle/data-ready timeouts and buffer overflow.

Parameters:
- FRAME_W, 256, frame width (4 lanes x 64 bits)
- SYNC_LEN, 4, nSYNC_OUT low time in MCLK cycles (>=1)
- SETTLE_TIMEOUT, 65535, max cycles in SETTLE before fault
- DRDY_TIMEOUT, 4096, max cycles between nDRDY falling edges in RUN
- CNT_W, 16, width of BURST_LEN and FRAME_COUNT

Ports:
- MCLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- START  in  1  begin session (sampled in IDLE only)
- STOP  in  1  end session / clear fault
- BURST_LEN  in  CNT_W  frames per session; 0 = continuous
- nDRDY  in  1  ADC data-ready, active-low
- nSYNC_OUT  out  1  ADC sync, active-low
- FRAME_STROBE  in  1  one-cycle pulse: FRAME_IN valid
- FRAME_IN  in  FRAME_W  captured frame
- OUT_VALID  out  1  output frame valid
- OUT_READY  in  1  consumer accepts
- OUT_DATA  out  FRAME_W  output frame
- OUT_TS  out  32  frame timestamp (see Optional Feature)
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse on session end
- ERR_TIMEOUT  out  1  sticky
- ERR_OVERFLOW  out  1  sticky
- DROP_COUNT  out  8  dropped frames, saturating at 255
- FRAME_COUNT  out  CNT_W  frames accepted this session

Behaviour:
- Reset, and default outputs: nSYNC_OUT=1, OUT_VALID=0, BUSY=0, DONE=0, errors=0, counts=0, FIFO empty, state IDLE. Reset mid-session gives the same result at the next edge; buffered frames are lost.
- nDRDY is registered once. A falling edge is detected when the previous sample is 1 and the current sample is 0, i.e. one cycle after the pin falls.
- IDLE: START=1 clears FRAME_COUNT, DROP_COUNT and sticky errors, latches BURST_LEN, then moves to SYNC. START in any other state is ignored.
- SYNC: nSYNC_OUT=0 for exactly SYNC_LEN cycles, starting the cycle after START, then SETTLE.
- SETTLE: FRAME_STROBE is ignored and not counted. A detected nDRDY falling edge moves to RUN. After SETTLE_TIMEOUT cycles with no edge: ERR_TIMEOUT=1, go to FAULT.
- RUN, on FRAME_STROBE:
  - FIFO not full, or full with a pop in the same cycle: push and FRAME_COUNT++.
  - FIFO full with no pop: drop the frame, ERR_OVERFLOW=1, DROP_COUNT++ (saturating). FRAME_COUNT is not incremented.
- RUN watchdog: resets on each nDRDY falling edge. Reaching DRDY_TIMEOUT sets ERR_TIMEOUT=1 and moves to FAULT.
- RUN exit: when BURST_LEN!=0 and FRAME_COUNT reaches BURST_LEN, go to DRAIN. STOP=1 also goes to DRAIN and has priority: a strobe in the same cycle is discarded.
- DRAIN: no pushes. When the FIFO is empty, assert DONE for 1 cycle and go to IDLE. The DONE cycle coincides with entry to IDLE.
- FAULT: FIFO flushed, OUT_VALID=0, nSYNC_OUT=1, BUSY=1. STOP returns to IDLE with no DONE pulse. Errors stay set until the next START.
- Output handshake: OUT_VALID/OUT_DATA/OUT_TS stay stable until OUT_READY. Pop on OUT_VALID & OUT_READY. Push-to-OUT_VALID latency is 1 cycle when empty. FIFO order is first-in first-out.
- FRAME_COUNT holds its final value in IDLE.

Optional Feature:
- Macro ADC_ACQ_TIMESTAMP_EN.
- Defined: a 32-bit free-running MCLK counter (reset 0, wraps) is latched on each detected nDRDY falling edge. The latched value is pushed alongside each frame and appears on OUT_TS with OUT_DATA.
- Undefined: no counter or FIFO storage for timestamps; OUT_TS is tied to 0.

Decomposition:
- Shared package adc_acq_pkg contains:
  - enum acq_state_t {IDLE, SYNC, SETTLE, RUN, DRAIN, FAULT}
  - localparams LANES=4, LANE_W=64, FRAME_W=LANES*LANE_W, TS_W=32
- Sub-module adc_frame_fifo2: 2-entry FIFO, parameterised width, with push/pop/full/empty/flush.
- The controller owns the FSM, counters and watchdogs.

Test Plan:
- Basic burst: BURST_LEN=3, START; nDRDY falls every 100 cycles with a strobe 70 cycles later; OUT_READY=1. Expect nSYNC_OUT low exactly 4 cycles, 3 frames out in order, FRAME_COUNT=3, DONE pulse, BUSY=0.
- Settle timeout: SETTLE_TIMEOUT=50, nDRDY held high. Expect FAULT after 50 cycles, ERR_TIMEOUT=1. STOP returns to IDLE with no DONE pulse.
- Overflow: continuous mode, OUT_READY=0, 5 strobes. Expect 2 buffered, ERR_OVERFLOW=1, DROP_COUNT=3, FRAME_COUNT=2. Release OUT_READY: 2 frames out, first-captured first.
- Full plus simultaneous pop: FIFO full, strobe in the same cycle as an OUT_READY pop. Expect the frame accepted and no overflow.
- STOP/strobe collision and mid-run reset:
  - STOP in the same cycle as a strobe: frame discarded, DRAIN, DONE.
  - nRST low mid-RUN: all outputs return to reset values next edge.
- With ADC_ACQ_TIMESTAMP_EN: OUT_TS of consecutive frames differs by exactly the nDRDY period (100). Without the macro, OUT_TS=0.

Source files
------------

// File: rtl/adc_acq_pkg.sv
// Shared types and constants for the ADC acquisition controller.
// Optional build macro: ADC_ACQ_TIMESTAMP_EN (see adc_acq_controller.sv).
package adc_acq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SETTLE,
    RUN,
    DRAIN,
    FAULT
  } acq_state_t;

  localparam int LANES   = 4;
  localparam int LANE_W  = 64;
  localparam int FRAME_W = LANES * LANE_W;
  localparam int TS_W    = 32;

  // Used to size the shared phase timer from the largest of its limits.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_frame_fifo2.sv
// Two-entry first-in first-out frame buffer with flush.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module adc_frame_fifo2 #(
  parameter int WIDTH = 256
) (
  input  logic             MCLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_reg[rd_ptr_reg];

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge MCLK) begin
    if (!nRST || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage write; contents need no reset because occupancy gates the output.
  always_ff @(posedge MCLK) begin
    if (do_push && !flush) mem_reg[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/adc_acq_controller.sv
// ADC acquisition session controller: nSYNC pulse, settle wait, frame gating
// into a 2-entry buffer, valid/ready hand-off, nDRDY watchdog and error flags.
// Optional build macro ADC_ACQ_TIMESTAMP_EN: when defined, every frame carries
// the free-running MCLK count latched at the most recent nDRDY falling edge.
module adc_acq_controller #(
  parameter int FRAME_W        = adc_acq_pkg::FRAME_W,
  parameter int SYNC_LEN       = 4,
  parameter int SETTLE_TIMEOUT = 65535,
  parameter int DRDY_TIMEOUT   = 4096,
  parameter int CNT_W          = 16
) (
  input  logic               MCLK,
  input  logic               nRST,
  input  logic               START,
  input  logic               STOP,
  input  logic [CNT_W-1:0]   BURST_LEN,
  input  logic               nDRDY,
  output logic               nSYNC_OUT,
  input  logic               FRAME_STROBE,
  input  logic [FRAME_W-1:0] FRAME_IN,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [FRAME_W-1:0] OUT_DATA,
  output logic [31:0]        OUT_TS,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR_TIMEOUT,
  output logic               ERR_OVERFLOW,
  output logic [7:0]         DROP_COUNT,
  output logic [CNT_W-1:0]   FRAME_COUNT
);

  import adc_acq_pkg::*;

  // One timer serves SYNC length, settle timeout and the RUN watchdog.
  localparam int TMR_W = $clog2(max_int(max_int(SYNC_LEN, SETTLE_TIMEOUT), DRDY_TIMEOUT) + 1);
  localparam logic [TMR_W-1:0] SYNC_LAST   = TMR_W'(SYNC_LEN - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DRDY_LAST   = TMR_W'(DRDY_TIMEOUT - 1);

`ifdef ADC_ACQ_TIMESTAMP_EN
  localparam int ENTRY_W = FRAME_W + TS_W;
`else
  localparam int ENTRY_W = FRAME_W;
`endif

  acq_state_t       state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0] burst_reg, burst_next;
  logic [CNT_W-1:0] frame_count_reg, frame_count_next;
  logic [7:0]       drop_count_reg, drop_count_next;
  logic             err_timeout_reg, err_timeout_next;
  logic             err_overflow_reg, err_overflow_next;
  logic             done_reg, done_next;
  logic             drdy_sample_reg, drdy_prev_reg;
  logic             drdy_fall;
  logic             push, pop, flush;
  logic             fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;

  assign drdy_fall = drdy_prev_reg && !drdy_sample_reg;

  // nDRDY is sampled once; the fall shows up one cycle after the pin drops.
  always_ff @(posedge MCLK) begin
    if (!nRST) begin
      drdy_sample_reg <= 1'b1;
      drdy_prev_reg   <= 1'b1;
    end else begin
      drdy_sample_reg <= nDRDY;
      drdy_prev_reg   <= drdy_sample_reg;
    end
  end

`ifdef ADC_ACQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_count_reg;
  logic [TS_W-1:0] ts_latch_reg;

  // Free-running cycle counter, captured on each detected nDRDY fall.
  always_ff @(posedge MCLK) begin
    if (!nRST) begin
      ts_count_reg <= '0;
      ts_latch_reg <= '0;
    end else begin
      ts_count_reg <= ts_count_reg + TS_W'(1);
      if (drdy_fall) ts_latch_reg <= ts_count_reg;
    end
  end

  assign fifo_din = {ts_latch_reg, FRAME_IN};
  assign OUT_TS   = fifo_dout[FRAME_W +: TS_W];
`else
  assign fifo_din = FRAME_IN;
  assign OUT_TS   = '0;
`endif

  adc_frame_fifo2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .MCLK  (MCLK),
    .nRST  (nRST),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign OUT_VALID    = !fifo_empty && (state_reg != FAULT);
  assign OUT_DATA     = fifo_dout[FRAME_W-1:0];
  assign pop          = OUT_VALID && OUT_READY;
  assign nSYNC_OUT    = (state_reg != SYNC);
  assign BUSY         = (state_reg != IDLE);
  assign DONE         = done_reg;
  assign ERR_TIMEOUT  = err_timeout_reg;
  assign ERR_OVERFLOW = err_overflow_reg;
  assign DROP_COUNT   = drop_count_reg;
  assign FRAME_COUNT  = frame_count_reg;

  // State, counters and sticky flags.
  always_ff @(posedge MCLK) begin
    if (!nRST) begin
      state_reg        <= IDLE;
      timer_reg        <= '0;
      burst_reg        <= '0;
      frame_count_reg  <= '0;
      drop_count_reg   <= '0;
      err_timeout_reg  <= 1'b0;
      err_overflow_reg <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      timer_reg        <= timer_next;
      burst_reg        <= burst_next;
      frame_count_reg  <= frame_count_next;
      drop_count_reg   <= drop_count_next;
      err_timeout_reg  <= err_timeout_next;
      err_overflow_reg <= err_overflow_next;
      done_reg         <= done_next;
    end
  end

  // Next-state, timer, push/drop decisions; STOP outranks a same-cycle strobe.
  always_comb begin
    state_next        = state_reg;
    timer_next        = timer_reg + TMR_W'(1);
    burst_next        = burst_reg;
    frame_count_next  = frame_count_reg;
    drop_count_next   = drop_count_reg;
    err_timeout_next  = err_timeout_reg;
    err_overflow_next = err_overflow_reg;
    done_next         = 1'b0;
    push              = 1'b0;
    flush             = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (START) begin
          frame_count_next  = '0;
          drop_count_next   = '0;
          err_timeout_next  = 1'b0;
          err_overflow_next = 1'b0;
          burst_next        = BURST_LEN;
          state_next        = SYNC;
        end
      end
      SYNC: begin
        if (STOP) begin
          state_next = DRAIN;
          timer_next = '0;
        end else if (timer_reg == SYNC_LAST) begin
          state_next = SETTLE;
          timer_next = '0;
        end
      end
      SETTLE: begin
        if (STOP) begin
          state_next = DRAIN;
          timer_next = '0;
        end else if (drdy_fall) begin
          state_next = RUN;
          timer_next = '0;
        end else if (timer_reg == SETTLE_LAST) begin
          state_next       = FAULT;
          err_timeout_next = 1'b1;
          timer_next       = '0;
        end
      end
      RUN: begin
        if (STOP) begin
          state_next = DRAIN;
          timer_next = '0;
        end else if (!drdy_fall && timer_reg == DRDY_LAST) begin
          state_next       = FAULT;
          err_timeout_next = 1'b1;
          timer_next       = '0;
        end else begin
          if (drdy_fall) timer_next = '0;
          if (FRAME_STROBE) begin
            if (!fifo_full || pop) begin
              push             = 1'b1;
              frame_count_next = frame_count_reg + CNT_W'(1);
              if (burst_reg != '0 && frame_count_next == burst_reg) begin
                state_next = DRAIN;
                timer_next = '0;
              end
            end else begin
              err_overflow_next = 1'b1;
              if (drop_count_reg != 8'hFF) drop_count_next = drop_count_reg + 8'd1;
            end
          end
        end
      end
      DRAIN: begin
        timer_next = '0;
        if (fifo_empty) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      FAULT: begin
        timer_next = '0;
        flush      = 1'b1;
        if (STOP) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_acq_controller.sv
// Directed testbench for adc_acq_controller (SETTLE_TIMEOUT=50, DRDY_TIMEOUT=300).
module tb_adc_acq_controller;

  logic         MCLK = 1'b0;
  logic         nRST = 1'b0;
  logic         START = 1'b0;
  logic         STOP = 1'b0;
  logic [15:0]  BURST_LEN = '0;
  logic         nDRDY = 1'b1;
  logic         nSYNC_OUT;
  logic         FRAME_STROBE = 1'b0;
  logic [255:0] FRAME_IN = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [255:0] OUT_DATA;
  logic [31:0]  OUT_TS;
  logic         BUSY;
  logic         DONE;
  logic         ERR_TIMEOUT;
  logic         ERR_OVERFLOW;
  logic [7:0]   DROP_COUNT;
  logic [15:0]  FRAME_COUNT;

  int tests = 0;
  int fails = 0;
  int phase = 0;
  bit auto_en = 1'b0;
  int sent = 0;
  int done_cnt = 0;
  int sync_low = 0;
  logic [255:0] got_q[$];
  logic [31:0]  ts_q[$];

  adc_acq_controller #(
    .FRAME_W        (256),
    .SYNC_LEN       (4),
    .SETTLE_TIMEOUT (50),
    .DRDY_TIMEOUT   (300),
    .CNT_W          (16)
  ) dut (
    .MCLK         (MCLK),
    .nRST         (nRST),
    .START        (START),
    .STOP         (STOP),
    .BURST_LEN    (BURST_LEN),
    .nDRDY        (nDRDY),
    .nSYNC_OUT    (nSYNC_OUT),
    .FRAME_STROBE (FRAME_STROBE),
    .FRAME_IN     (FRAME_IN),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .OUT_DATA     (OUT_DATA),
    .OUT_TS       (OUT_TS),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERR_TIMEOUT  (ERR_TIMEOUT),
    .ERR_OVERFLOW (ERR_OVERFLOW),
    .DROP_COUNT   (DROP_COUNT),
    .FRAME_COUNT  (FRAME_COUNT)
  );

  always #5 MCLK = ~MCLK;

  function automatic logic [255:0] mkf(input int k);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = 32'(k * 16 + i) ^ 32'hA5000000;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor the cycle about to be clocked, then advance one edge and drive
  // the optional periodic nDRDY (period 100, low 50) / strobe (70 after fall).
  task automatic cyc();
    if (!nSYNC_OUT) sync_low++;
    if (DONE) done_cnt++;
    if (OUT_VALID && OUT_READY) begin
      got_q.push_back(OUT_DATA);
      ts_q.push_back(OUT_TS);
    end
    @(posedge MCLK);
    #1;
    FRAME_STROBE = 1'b0;
    if (auto_en) begin
      phase = (phase + 1) % 100;
      nDRDY = (phase < 50) ? 1'b0 : 1'b1;
      if (phase == 70) begin
        FRAME_STROBE = 1'b1;
        FRAME_IN = mkf(sent);
        sent++;
      end
    end
  endtask

  // START, let SYNC/SETTLE run, then one nDRDY fall; RUN is entered by the last cycle.
  task automatic enter_run();
    START = 1'b1;
    cyc();
    START = 1'b0;
    repeat (6) cyc();
    nDRDY = 1'b0;
    repeat (3) cyc();
    nDRDY = 1'b1;
  endtask

  task automatic strobe(input int k);
    FRAME_STROBE = 1'b1;
    FRAME_IN = mkf(k);
    cyc();
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (3) cyc();
    chk("rst_nsync", nSYNC_OUT, 1'b1);
    chk("rst_valid", OUT_VALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_errs", {ERR_TIMEOUT, ERR_OVERFLOW}, 2'b00);
    chk("rst_counts", {DROP_COUNT, FRAME_COUNT}, 24'h0);
    chk("rst_ts", OUT_TS, 32'h0);
    nRST = 1'b1;
    cyc();

    // ---------------- basic burst of 3 ----------------
    BURST_LEN = 16'd3;
    OUT_READY = 1'b1;
    START = 1'b1;
    sync_low = 0;
    done_cnt = 0;
    cyc();
    START = 1'b0;
    chk("burst_busy", BUSY, 1'b1);
    chk("burst_nsync_low", nSYNC_OUT, 1'b0);
    phase = 80;
    auto_en = 1'b1;
    for (int i = 0; i < 600 && done_cnt == 0; i++) cyc();
    auto_en = 1'b0;
    nDRDY = 1'b1;
    repeat (3) cyc();
    chk("burst_done_once", done_cnt, 1);
    chk("burst_sync_len", sync_low, 4);
    chk("burst_nframes", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("burst_f0", got_q[0], mkf(0));
      chk("burst_f1", got_q[1], mkf(1));
      chk("burst_f2", got_q[2], mkf(2));
`ifdef ADC_ACQ_TIMESTAMP_EN
      chk("ts_delta01", ts_q[1] - ts_q[0], 32'd100);
      chk("ts_delta12", ts_q[2] - ts_q[1], 32'd100);
`else
      chk("ts_zero0", ts_q[0], 32'h0);
      chk("ts_zero2", ts_q[2], 32'h0);
`endif
    end
    chk("burst_count", FRAME_COUNT, 16'd3);
    chk("burst_idle", BUSY, 1'b0);

    // ---------------- settle timeout ----------------
    START = 1'b1;
    cyc();
    START = 1'b0;
    done_cnt = 0;
    repeat (53) cyc();
    chk("settle_before", ERR_TIMEOUT, 1'b0);
    cyc();
    chk("settle_err", ERR_TIMEOUT, 1'b1);
    chk("settle_fault_busy", BUSY, 1'b1);
    chk("settle_fault_nsync", nSYNC_OUT, 1'b1);
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    chk("fault_stop_idle", BUSY, 1'b0);
    repeat (3) cyc();
    chk("fault_no_done", done_cnt, 0);
    chk("fault_err_sticky", ERR_TIMEOUT, 1'b1);

    // ---------------- overflow, continuous mode ----------------
    BURST_LEN = 16'd0;
    OUT_READY = 1'b0;
    enter_run();
    chk("start_clears_count", FRAME_COUNT, 16'd0);
    chk("start_clears_err", ERR_TIMEOUT, 1'b0);
    strobe(10);
    chk("push_latency_valid", OUT_VALID, 1'b1);
    chk("push_latency_data", OUT_DATA, mkf(10));
    cyc();
    for (int k = 11; k < 15; k++) begin
      strobe(k);
      cyc();
    end
    chk("ovf_count", FRAME_COUNT, 16'd2);
    chk("ovf_drops", DROP_COUNT, 8'd3);
    chk("ovf_flag", ERR_OVERFLOW, 1'b1);
    chk("ovf_head_stable", OUT_DATA, mkf(10));
    got_q.delete();
    ts_q.delete();
    OUT_READY = 1'b1;
    repeat (4) cyc();
    chk("ovf_nout", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("ovf_out0", got_q[0], mkf(10));
      chk("ovf_out1", got_q[1], mkf(11));
    end
    chk("ovf_empty", OUT_VALID, 1'b0);
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    repeat (3) cyc();

    // ---------------- full buffer plus simultaneous pop ----------------
    OUT_READY = 1'b0;
    enter_run();
    strobe(20);
    cyc();
    strobe(21);
    cyc();
    got_q.delete();
    ts_q.delete();
    OUT_READY = 1'b1;
    strobe(22);
    chk("fullpop_no_ovf", ERR_OVERFLOW, 1'b0);
    chk("fullpop_no_drop", DROP_COUNT, 8'd0);
    chk("fullpop_count", FRAME_COUNT, 16'd3);
    repeat (3) cyc();
    chk("fullpop_nout", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("fullpop_out0", got_q[0], mkf(20));
      chk("fullpop_out1", got_q[1], mkf(21));
      chk("fullpop_out2", got_q[2], mkf(22));
    end

    // ---------------- STOP collides with strobe ----------------
    done_cnt = 0;
    STOP = 1'b1;
    strobe(30);
    STOP = 1'b0;
    chk("stop_discard_count", FRAME_COUNT, 16'd3);
    repeat (3) cyc();
    chk("stop_done", done_cnt, 1);
    chk("stop_idle", BUSY, 1'b0);
    chk("stop_no_frame", got_q.size(), 3);
    chk("idle_count_hold", FRAME_COUNT, 16'd3);

    // ---------------- reset in the middle of RUN ----------------
    OUT_READY = 1'b0;
    enter_run();
    strobe(40);
    cyc();
    chk("midrun_valid", OUT_VALID, 1'b1);
    chk("midrun_count", FRAME_COUNT, 16'd1);
    nRST = 1'b0;
    cyc();
    chk("midrst_valid", OUT_VALID, 1'b0);
    chk("midrst_busy", BUSY, 1'b0);
    chk("midrst_nsync", nSYNC_OUT, 1'b1);
    chk("midrst_counts", {DROP_COUNT, FRAME_COUNT}, 24'h0);
    chk("midrst_flags", {DONE, ERR_TIMEOUT, ERR_OVERFLOW}, 3'b000);
    nRST = 1'b1;
    cyc();
    chk("midrst_stays_empty", OUT_VALID, 1'b0);

    // ---------------- nDRDY watchdog in RUN ----------------
    enter_run();
    strobe(50);
    repeat (250) cyc();
    chk("wd_not_yet", ERR_TIMEOUT, 1'b0);
    chk("wd_frame_held", OUT_VALID, 1'b1);
    repeat (70) cyc();
    chk("wd_err", ERR_TIMEOUT, 1'b1);
    chk("wd_flushed", OUT_VALID, 1'b0);
    chk("wd_busy", BUSY, 1'b1);
    done_cnt = 0;
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    repeat (2) cyc();
    chk("wd_stop_idle", BUSY, 1'b0);
    chk("wd_no_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
